// File: rtl/f_pkg.sv
// Shared constants, state encoding and field helpers for the binary32 post-normalizer.
// The adder significand carries an extra carry bit above the hidden bit.
package f_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int MANT_W  = FRAC_W + 2;
  localparam int WORD_W  = 1 + EXP_W + FRAC_W;
  localparam int EXP_MAX = 255;
  localparam int BIAS    = 127;

  // Packed word field positions
  localparam int SIGN_BIT = WORD_W - 1;
  localparam int EXP_HI   = WORD_W - 2;
  localparam int EXP_LO   = FRAC_W;
  localparam int FRAC_HI  = FRAC_W - 1;
  localparam int FRAC_LO  = 0;

  // Significand field positions
  localparam int CARRY_BIT  = FRAC_W + 1;
  localparam int HIDDEN_BIT = FRAC_W;

  // NORM never needs more than 24 evaluations for a legal input.
  localparam int ITER_MAX = 25;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [WORD_W-1:0] pack_word(
    input logic              sign,
    input logic [EXP_W-1:0]  exp,
    input logic [FRAC_W-1:0] frac
  );
    return {sign, exp, frac};
  endfunction

endpackage

// File: rtl/f_normalizer.sv
// Sequential post-normalizer: one shift per cycle after cancellation, right shift on carry,
// packs a binary32 result with zero/overflow/underflow flags behind a valid/ready handshake.
module f_normalizer
  import f_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [EXP_W-1:0]     in_exp,
  input  logic [MANT_W-1:0]    in_mant,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_W-1:0]    out,
  output logic                 zero,
  output logic                 ovf,
  output logic                 uf
);

  state_t              state_reg;
  logic                sign_reg;
  logic [EXP_W:0]      exp_reg;
  logic [MANT_W-1:0]   mant_reg;
  logic [4:0]          iter_cnt_reg;

  logic [EXP_W:0]      exp_inc;
  logic [EXP_W:0]      exp_dec;

  assign exp_inc  = exp_reg + 9'd1;
  assign exp_dec  = exp_reg - 9'd1;
  assign in_ready = (state_reg == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      sign_reg     <= 1'b0;
      exp_reg      <= '0;
      mant_reg     <= '0;
      iter_cnt_reg <= '0;
      out          <= '0;
      out_valid    <= 1'b0;
      zero         <= 1'b0;
      ovf          <= 1'b0;
      uf           <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            sign_reg     <= in_sign;
            exp_reg      <= {1'b0, in_exp};
            mant_reg     <= in_mant;
            iter_cnt_reg <= '0;
            state_reg    <= NORM;
          end
        end

        NORM: begin
          iter_cnt_reg <= iter_cnt_reg + 5'd1;
          if (exp_reg == 9'(EXP_MAX)) begin
            // Inf/NaN from the adder passes through untouched.
            out       <= pack_word(sign_reg, exp_reg[EXP_W-1:0], mant_reg[FRAC_HI:FRAC_LO]);
            out_valid <= 1'b1;
            state_reg <= DONE;
          end else if (mant_reg == '0) begin
            out       <= '0;
            zero      <= 1'b1;
            out_valid <= 1'b1;
            state_reg <= DONE;
          end else if (exp_reg == '0) begin
            out       <= pack_word(sign_reg, '0, '0);
            uf        <= 1'b1;
            out_valid <= 1'b1;
            state_reg <= DONE;
          end else if (mant_reg[CARRY_BIT]) begin
            mant_reg <= mant_reg >> 1;
            exp_reg  <= exp_inc;
            if (exp_inc == 9'(EXP_MAX)) begin
              out       <= pack_word(sign_reg, '1, '0);
              ovf       <= 1'b1;
              out_valid <= 1'b1;
              state_reg <= DONE;
            end
          end else if (mant_reg[HIDDEN_BIT]) begin
            out       <= pack_word(sign_reg, exp_reg[EXP_W-1:0], mant_reg[FRAC_HI:FRAC_LO]);
            out_valid <= 1'b1;
            state_reg <= DONE;
          end else if (exp_reg == 9'd1 || iter_cnt_reg == 5'(ITER_MAX - 1)) begin
            // Cannot shift further without entering the denormal range.
            out       <= pack_word(sign_reg, '0, '0);
            uf        <= 1'b1;
            out_valid <= 1'b1;
            state_reg <= DONE;
          end else begin
            mant_reg <= mant_reg << 1;
            exp_reg  <= exp_dec;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            uf        <= 1'b0;
            state_reg <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_f_normalizer.sv
// Directed bench for f_normalizer: hand-computed results, latencies, backpressure and mid-op reset.
module tb_f_normalizer;
  import f_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [7:0]        in_exp;
  logic [24:0]       in_mant;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out;
  logic              zero;
  logic              ovf;
  logic              uf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  f_normalizer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zero(zero), .ovf(ovf), .uf(uf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One transaction: accept, wait for the result, optionally stall, then hand it off.
  task automatic run(input string tag, input logic s, input logic [7:0] e, input logic [24:0] m,
                     input logic [31:0] x_out, input logic x_zero, input logic x_ovf,
                     input logic x_uf, input int x_lat, input int hold);
    int lat;
    logic [31:0] held;
    @(negedge clk);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_sign   = s;
    in_exp    = e;
    in_mant   = m;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (!out_valid) check({tag, ".busy_in_ready"}, 32'(in_ready), 32'd0);
    end
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".latency_bound"}, 32'(lat <= ITER_MAX), 32'd1);
    check({tag, ".latency"}, 32'(lat), 32'(x_lat));
    check({tag, ".out"}, out, x_out);
    check({tag, ".flags"}, {29'd0, zero, ovf, uf}, {29'd0, x_zero, x_ovf, x_uf});
    held = out;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".hold_out"}, out, held);
      check({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, ".post_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".post_flags"}, {29'd0, zero, ovf, uf}, 32'd0);
    check({tag, ".post_in_ready"}, 32'(in_ready), 32'd1);
    $display("txn %s: sign=%0b exp=%h mant=%h -> out=%h z=%0b o=%0b u=%0b lat=%0d",
             tag, s, e, m, held, x_zero, x_ovf, x_uf, lat);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.out", out, 32'h0);
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.flags", {29'd0, zero, ovf, uf}, 32'd0);
    check("reset.in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;

    run("normalized", 1'b0, 8'h80, 25'h0C00000, 32'h40400000, 0, 0, 0, 2, 0);
    run("carry",      1'b0, 8'h7F, 25'h1000000, 32'h40000000, 0, 0, 0, 3, 0);
    run("overflow",   1'b0, 8'hFE, 25'h1000000, 32'h7F800000, 0, 1, 0, 2, 0);
    run("cancel15",   1'b0, 8'h85, 25'h0000100, 32'h3B000000, 0, 0, 0, 17, 0);
    run("zero_neg",   1'b1, 8'h40, 25'h0000000, 32'h00000000, 1, 0, 0, 2, 0);
    run("underflow",  1'b0, 8'h03, 25'h0000001, 32'h00000000, 0, 0, 1, 4, 0);
    run("uf_neg",     1'b1, 8'h00, 25'h0800000, 32'h80000000, 0, 0, 1, 2, 0);
    run("passthru",   1'b0, 8'hFF, 25'h0123456, 32'h7F923456, 0, 0, 0, 2, 0);
    run("max_shift",  1'b1, 8'h80, 25'h0000001, 32'hB4800000, 0, 0, 0, 25, 0);
    run("backpress",  1'b0, 8'h80, 25'h0C00000, 32'h40400000, 0, 0, 0, 2, 10);

    // Abort the cancellation case part-way through its shifts.
    @(negedge clk);
    in_sign  = 1'b0;
    in_exp   = 8'h85;
    in_mant  = 25'h0000100;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort.out_valid", 32'(out_valid), 32'd0);
    check("abort.out", out, 32'h0);
    check("abort.flags", {29'd0, zero, ovf, uf}, 32'd0);
    rst = 1'b0;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      check("abort.no_output", 32'(out_valid), 32'd0);
    end
    $display("txn abort: reset during cancellation, no result produced");

    run("after_abort", 1'b0, 8'h85, 25'h0000100, 32'h3B000000, 0, 0, 0, 17, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
